pushbutton_conditioner: RTL and testbench

PUSHBUTTON_CONDITIONER -- requirements
Module: pushbutton_conditioner

---
 rtl/pushbutton_pkg.sv | 21 ++
 rtl/button_channel.sv | 110 +++++++++++
 rtl/pushbutton_conditioner.sv | 36 +++
 tb/tb_pushbutton_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pushbutton_pkg.sv
// Shared definitions for the pushbutton conditioner: the repeat FSM state
// encoding, the default timing constants and the counter width helper.
package pushbutton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_N_BUTTONS           = 4;
  localparam int DEF_DEBOUNCE_CYCLES     = 1000000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

  // A terminal count of n-1 always fits in $clog2(n) bits; keep at least 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce counter and auto-repeat FSM.
// A clean key edge reaches stable_n 2+DEBOUNCE_CYCLES cycles later; the pulses are registered and carry no backpressure.
module button_channel
  import pushbutton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_n,
  output logic stable_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW   = cnt_width(RMAX);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rep_cnt;
  rep_state_t    state;
  logic          deb_done;
  logic          accept_press;
  logic          accept_release;

  always_comb begin
    deb_done       = (sync_q2 != stable_n) && (deb_cnt == DEB_LAST);
    accept_press   = deb_done && !sync_q2;
    accept_release = deb_done && sync_q2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1       <= 1'b1;
      sync_q2       <= 1'b1;
      stable_n      <= 1'b1;
      deb_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q1       <= key_raw_n;
      sync_q2       <= sync_q1;
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      if (deb_done) begin
        stable_n <= sync_q2;
        deb_cnt  <= '0;
      end else if (sync_q2 != stable_n) begin
        deb_cnt <= deb_cnt + DW'(1);
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Release takes priority over everything, so a coinciding terminal count never pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (accept_release) begin
        state   <= ST_IDLE;
        rep_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            rep_cnt <= '0;
            if (accept_press) state <= ST_HOLD_DELAY;
          end
          ST_HOLD_DELAY: begin
            if (rep_cnt == DELAY_LAST) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
              state        <= ST_HOLD_REPEAT;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          ST_HOLD_REPEAT: begin
            if (rep_cnt == RATE_LAST) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pushbutton_conditioner.sv
// N_BUTTONS independent debounced pushbutton channels with press/release/auto-repeat pulses.
// Latency 2+DEBOUNCE_CYCLES from key edge to stable level; outputs are free-running, no backpressure.
module pushbutton_conditioner
  import pushbutton_pkg::*;
#(
  parameter int N_BUTTONS           = DEF_N_BUTTONS,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic                 ref_clk_clk,
  input  logic                 ref_reset_reset,
  input  logic [N_BUTTONS-1:0] key_n,
  output logic [N_BUTTONS-1:0] btn_stable_n,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk          (ref_clk_clk),
      .rst          (ref_reset_reset),
      .key_raw_n    (key_n[i]),
      .stable_n     (btn_stable_n[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .repeat_pulse (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner: directed scenarios with literal expectations,
// then randomized key activity compared every cycle against a timestamp-based model.
module tb_pushbutton_conditioner;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic          clk;
  logic          rst;
  logic [NB-1:0] key_n;
  logic [NB-1:0] btn_stable_n;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;

  int checks   = 0;
  int failures = 0;

  pushbutton_conditioner #(
    .N_BUTTONS          (NB),
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .ref_clk_clk    (clk),
    .ref_reset_reset(rst),
    .key_n          (key_n),
    .btn_stable_n   (btn_stable_n),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .btn_repeat     (btn_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: edge timestamps instead of counters.
  // A level is accepted once the synchronized sample has disagreed with it for DEB
  // consecutive edges; repeats fall at press+RD+k*RR while the level stays pressed.
  logic [NB-1:0] m_s1      = '1;
  logic [NB-1:0] m_s2      = '1;
  logic [NB-1:0] m_stable  = '1;
  logic [NB-1:0] m_press   = '0;
  logic [NB-1:0] m_rel     = '0;
  logic [NB-1:0] m_rep     = '0;
  logic [NB-1:0] m_held    = '0;
  int            last_agree[NB];
  int            press_edge[NB];
  int            edge_no   = 0;
  bit            cmp_en    = 0;

  task automatic model_step();
    logic samp;
    int   d;
    edge_no++;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1;
      m_press = '0; m_rel = '0; m_rep = '0; m_held = '0;
      for (int i = 0; i < NB; i++) last_agree[i] = edge_no;
    end else begin
      for (int i = 0; i < NB; i++) begin
        samp = m_s2[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
        if (samp == m_stable[i]) begin
          last_agree[i] = edge_no;
        end else if (edge_no - last_agree[i] >= DEB) begin
          m_stable[i]   = samp;
          last_agree[i] = edge_no;
          if (!samp) begin
            m_press[i] = 1'b1; m_held[i] = 1'b1; press_edge[i] = edge_no;
          end else begin
            m_rel[i] = 1'b1; m_held[i] = 1'b0;
          end
        end
        if (m_held[i] && !m_press[i]) begin
          d = edge_no - press_edge[i];
          if (d >= RD && ((d - RD) % RR) == 0) m_rep[i] = 1'b1;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = key_n[i];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      last_agree[i] = 0;
      press_edge[i] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
      cmp_en = 1;
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h edge=%0d", name, act, exp, edge_no);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("model_stable_n", btn_stable_n, m_stable);
        chk("model_press",    btn_press,    m_press);
        chk("model_release",  btn_release,  m_rel);
        chk("model_repeat",   btn_repeat,   m_rep);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  reps[3];
  int  nrep;
  int  late_rep;
  logic quiet;

  initial begin
    rst   = 1'b1;
    key_n = '1;
    wait_n(3);
    chk("reset_stable_n", btn_stable_n, 4'hF);
    chk("reset_pulses", btn_press | btn_release | btn_repeat, 4'h0);
    rst = 1'b0;
    wait_n(2);

    // Clean press on channel 0: accepted 6 cycles after the key edge.
    key_n[0] = 1'b0;
    wait_n(5);
    chk("ch0_stable_before", {3'b0, btn_stable_n[0]}, 4'h1);
    chk("ch0_press_before",  {3'b0, btn_press[0]},    4'h0);
    wait_n(1);
    chk("ch0_stable_at6", {3'b0, btn_stable_n[0]}, 4'h0);
    chk("ch0_press_at6",  {3'b0, btn_press[0]},    4'h1);
    chk("model_ch0_press_at6", {3'b0, m_press[0]}, 4'h1);
    wait_n(1);
    chk("ch0_press_after", {3'b0, btn_press[0]}, 4'h0);

    // 3-cycle glitch on channel 1 must be ignored.
    key_n[1] = 1'b0;
    wait_n(3);
    key_n[1] = 1'b1;
    quiet = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_n(1);
      quiet = quiet | btn_press[1] | btn_release[1] | ~btn_stable_n[1];
    end
    chk("ch1_glitch_quiet", {3'b0, quiet}, 4'h0);

    // Long hold on channel 2: repeats at +10, +13, +16, release ends them.
    key_n[2] = 1'b0;
    wait_n(6);
    chk("ch2_press", {3'b0, btn_press[2]}, 4'h1);
    chk("ch2_no_repeat_with_press", {3'b0, btn_repeat[2]}, 4'h0);
    nrep = 0;
    for (int i = 0; i < 3; i++) reps[i] = -1;
    for (int k = 1; k <= 30; k++) begin
      wait_n(1);
      if (btn_repeat[2] && nrep < 3) begin
        reps[nrep] = k;
        nrep++;
      end
    end
    chk("ch2_repeat1_offset", 4'(reps[0]), 4'(10));
    chk("ch2_repeat2_offset", 4'(reps[1]), 4'(13));
    chk("ch2_repeat3_offset", 4'(reps[2]), 4'(16));
    key_n[2] = 1'b1;
    late_rep = 0;
    for (int k = 31; k <= 45; k++) begin
      wait_n(1);
      if (k == 34) chk("ch2_repeat_at34", {3'b0, btn_repeat[2]}, 4'h1);
      if (k == 36) chk("ch2_release_at36", {3'b0, btn_release[2]}, 4'h1);
      if (k > 36 && btn_repeat[2]) late_rep++;
    end
    chk("ch2_no_repeat_after_release", 4'(late_rep), 4'h0);

    // Release accepted on the first repeat's terminal edge: release wins.
    key_n[1] = 1'b0;
    wait_n(6);
    chk("ch1_press", {3'b0, btn_press[1]}, 4'h1);
    wait_n(4);
    key_n[1] = 1'b1;
    wait_n(6);
    chk("ch1_release_coincide", {3'b0, btn_release[1]}, 4'h1);
    chk("ch1_repeat_suppressed", {3'b0, btn_repeat[1]}, 4'h0);
    chk("model_ch1_repeat_suppressed", {3'b0, m_rep[1]}, 4'h0);

    // Button held through reset is re-accepted 6 cycles after reset release.
    rst      = 1'b1;
    key_n[3] = 1'b0;
    wait_n(3);
    chk("rst_hold_stable_n", {3'b0, btn_stable_n[3]}, 4'h1);
    rst = 1'b0;
    wait_n(5);
    chk("ch3_press_before", {3'b0, btn_press[3]}, 4'h0);
    wait_n(1);
    chk("ch3_press_at6",  {3'b0, btn_press[3]},    4'h1);
    chk("ch3_stable_at6", {3'b0, btn_stable_n[3]}, 4'h0);
    chk("model_ch3_press_at6", {3'b0, m_press[3]}, 4'h1);

    // Random activity: alternating bouncy and slow phases, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int ch = 0; ch < NB; ch++) begin
        if ($urandom_range(0, ((c / 500) % 2 == 1) ? 40 : 6) == 0)
          key_n[ch] = ~key_n[ch];
      end
    end
    rst = 1'b0;
    wait_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
